// File: rtl/pe_array_output_collector_pkg.sv
// pe_array_pkg: shared defaults, collector FSM state enum and PE word type
`ifndef N_PE
`define N_PE 4
`endif
`ifndef WID_PE_BITS
`define WID_PE_BITS 16
`endif
package pe_array_pkg;
  localparam int DEF_N_PE = `N_PE;
  localparam int DEF_WID_PE_BITS = `WID_PE_BITS;
  localparam int DEF_ADDR_W = 16;
  typedef enum logic {IDLE, EMIT} col_state_t;
  typedef logic [DEF_WID_PE_BITS-1:0] pe_word_t;
endpackage

// File: rtl/pe_array_output_collector_if.sv
// pe_array_output_collector_if: valid/ready write port (valid, ready, addr, data); master drives the request, slave accepts it
interface pe_array_output_collector_if
  import pe_array_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DW = DEF_WID_PE_BITS
);
  logic valid;
  logic ready;
  logic [ADDR_W-1:0] addr;
  logic [DW-1:0] data;
  modport master(output valid, addr, data, input ready);
  modport slave(input valid, addr, data, output ready);
endinterface

// File: rtl/pe_array_output_collector_vec_fifo.sv
// pe_vec_fifo: 2-entry {mask, bus} FIFO; in: clk, rst, flush, push, pop, din_*; out: head_*, next_* (second entry), full, empty, count
module pe_vec_fifo
  import pe_array_pkg::*;
#(
  parameter int N_PE = DEF_N_PE,
  parameter int WID_PE_BITS = DEF_WID_PE_BITS
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  logic pop,
  input  logic [N_PE-1:0] din_mask,
  input  logic [N_PE*WID_PE_BITS-1:0] din_bus,
  output logic [N_PE-1:0] head_mask,
  output logic [N_PE*WID_PE_BITS-1:0] head_bus,
  output logic [N_PE-1:0] next_mask,
  output logic [N_PE*WID_PE_BITS-1:0] next_bus,
  output logic full,
  output logic empty,
  output logic [1:0] count
);
  localparam int EW = N_PE + N_PE * WID_PE_BITS;
  logic [EW-1:0] mem [2];
  logic rd;
  logic [0:0] wr_idx;
  assign wr_idx = flush ? 1'b0 : rd ^ count[0];
  always_ff @(posedge clk)
    if (push) mem[wr_idx] <= {din_mask, din_bus};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd <= 1'b0;
      count <= 2'd0;
    end else if (flush) begin
      rd <= 1'b0;
      count <= {1'b0, push};
    end else begin
      rd <= rd ^ pop;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  assign {head_mask, head_bus} = mem[rd];
  assign {next_mask, next_bus} = mem[~rd];
  assign full = count == 2'd2;
  assign empty = count == 2'd0;
endmodule

// File: rtl/pe_array_output_collector.sv
// pe_array_output_collector: buffers PE result vectors and serializes active lanes to an addressed write port; ports clk, rst, start, base_addr, out_valid/out_bus/out_mask, capture_ready, wr (master), busy, overflow, words_written
module pe_array_output_collector
  import pe_array_pkg::*;
#(
  parameter int N_PE = DEF_N_PE,
  parameter int WID_PE_BITS = DEF_WID_PE_BITS,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic out_valid,
  input  logic [N_PE*WID_PE_BITS-1:0] out_bus,
  input  logic [N_PE-1:0] out_mask,
  output logic capture_ready,
  pe_array_output_collector_if.master wr,
  output logic busy,
  output logic overflow,
  output logic [15:0] words_written
);
  localparam int LW = N_PE > 1 ? $clog2(N_PE) : 1;
  function automatic logic [LW:0] first_set(input logic [N_PE-1:0] m, input int from);
    first_set = '0;
    for (int i = N_PE - 1; i >= 0; i--)
      if (m[i] && i >= from) first_set = {1'b1, LW'(i)};
  endfunction
  logic [N_PE-1:0] head_mask, next_mask;
  logic [N_PE*WID_PE_BITS-1:0] head_bus, next_bus, src;
  logic full, empty, push, pop, accept;
  logic [1:0] count;
  col_state_t state, state_n;
  logic [LW-1:0] lane, lane_n;
  logic [LW:0] adv, head_first, next_first;
  logic [ADDR_W-1:0] ptr;
  logic [WID_PE_BITS-1:0] data, data_n;
  assign push = out_valid && (start || !full);
  pe_vec_fifo #(.N_PE(N_PE), .WID_PE_BITS(WID_PE_BITS)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(start),
    .push(push),
    .pop(pop),
    .din_mask(out_mask),
    .din_bus(out_bus),
    .head_mask(head_mask),
    .head_bus(head_bus),
    .next_mask(next_mask),
    .next_bus(next_bus),
    .full(full),
    .empty(empty),
    .count(count)
  );
  assign adv = first_set(head_mask, int'(lane) + 1);
  assign head_first = first_set(head_mask, 0);
  assign next_first = first_set(next_mask, 0);
  assign accept = state == EMIT && wr.ready;
  // on the last lane of the head, jump straight to a buffered second vector to keep 1 word/cycle
  always_comb begin
    state_n = state;
    lane_n = lane;
    pop = 1'b0;
    src = head_bus;
    if (state == IDLE && !empty) begin
      pop = !head_first[LW];
      state_n = head_first[LW] ? EMIT : IDLE;
      lane_n = head_first[LW-1:0];
    end else if (accept) begin
      pop = !adv[LW];
      state_n = adv[LW] || (count == 2'd2 && next_first[LW]) ? EMIT : IDLE;
      lane_n = adv[LW] ? adv[LW-1:0] : next_first[LW-1:0];
      src = adv[LW] ? head_bus : next_bus;
    end
    data_n = src[lane_n*WID_PE_BITS +: WID_PE_BITS];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      lane <= '0;
      data <= '0;
      ptr <= '0;
      words_written <= '0;
      overflow <= 1'b0;
    end else if (start) begin
      state <= IDLE;
      ptr <= base_addr;
      words_written <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      lane <= lane_n;
      if (state_n == EMIT) data <= data_n;
      if (accept) begin
        ptr <= ptr + ADDR_W'(1);
        words_written <= words_written + 16'(words_written != 16'hFFFF);
      end
      if (out_valid && full) overflow <= 1'b1;
    end
  assign capture_ready = !full;
  assign busy = state == EMIT || !empty;
  assign wr.valid = state == EMIT;
  assign wr.addr = ptr;
  assign wr.data = data;
endmodule

// File: tb/tb_pe_array_output_collector.sv
// tb_pe_array_output_collector: table-driven, directed and randomized checks of the PE output collector
module tb_pe_array_output_collector;
  import pe_array_pkg::*;
  localparam logic [63:0] B1 = 64'h0004_0003_0002_0001;
  localparam logic [63:0] B2 = 64'hdead_beef_cafe_f00d;
  typedef struct {
    logic restart;
    logic [15:0] base;
    logic [3:0] mask;
    logic [63:0] bus;
    int n;
    logic [3:0][15:0] ea;
    logic [3:0][15:0] ed;
    logic [15:0] words;
  } vec_t;
  logic clk = 0, rst = 1, start = 0, out_valid = 0;
  logic [15:0] base_addr = 0;
  logic [63:0] out_bus = 0;
  logic [3:0] out_mask = 0;
  logic capture_ready, busy, overflow;
  logic [15:0] words_written;
  int checks = 0, errors = 0;
  logic [31:0] got[$];
  pe_word_t exp_q[$];
  vec_t tbl[6];
  logic pv = 0;
  logic [15:0] pa = 0, pd = 0;
  pe_array_output_collector_if #(.ADDR_W(16), .DW(16)) wr_if ();
  pe_array_output_collector #(.N_PE(4), .WID_PE_BITS(16), .ADDR_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_addr(base_addr),
    .out_valid(out_valid),
    .out_bus(out_bus),
    .out_mask(out_mask),
    .capture_ready(capture_ready),
    .wr(wr_if),
    .busy(busy),
    .overflow(overflow),
    .words_written(words_written)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL global_timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_start(input logic [15:0] b);
    start = 1;
    base_addr = b;
    tick();
    start = 0;
    got.delete();
  endtask
  task automatic send(input logic [3:0] m, input logic [63:0] b);
    out_valid = 1;
    out_mask = m;
    out_bus = b;
    tick();
    out_valid = 0;
  endtask
  task automatic drain();
    wr_if.ready = 1;
    for (int c = 0; c < 60 && busy; c++) tick();
    chk("drain_idle", busy, 0);
  endtask
  // accepted writes are logged, and a stalled request must be unchanged one cycle later
  always @(negedge clk) begin
    if (!rst && !start && pv)
      chk("stall_hold", {wr_if.valid, wr_if.addr, wr_if.data}, {1'b1, pa, pd});
    pv = wr_if.valid && !wr_if.ready && !start && !rst;
    pa = wr_if.addr;
    pd = wr_if.data;
    if (wr_if.valid && wr_if.ready && !start && !rst) got.push_back({wr_if.addr, wr_if.data});
  end
  initial begin
    logic [6:0] pat;
    logic [15:0] ov_d[8];
    logic [15:0] rbase;
    logic [3:0] m;
    logic [63:0] b;
    int sent;
    tbl[0] = '{1'b1, 16'h0100, 4'b1111, B1, 4, {16'h0103, 16'h0102, 16'h0101, 16'h0100}, {16'h4, 16'h3, 16'h2, 16'h1}, 16'd4};
    tbl[1] = '{1'b1, 16'h0100, 4'b0101, B1, 2, {16'h0, 16'h0, 16'h0101, 16'h0100}, {16'h0, 16'h0, 16'h3, 16'h1}, 16'd2};
    tbl[2] = '{1'b0, 16'h0000, 4'b0000, B1, 0, '0, '0, 16'd2};
    tbl[3] = '{1'b0, 16'h0000, 4'b1010, B2, 2, {16'h0, 16'h0, 16'h0103, 16'h0102}, {16'h0, 16'h0, 16'hdead, 16'hcafe}, 16'd4};
    tbl[4] = '{1'b1, 16'hFFFE, 4'b1111, B1, 4, {16'h0001, 16'h0000, 16'hFFFF, 16'hFFFE}, {16'h4, 16'h3, 16'h2, 16'h1}, 16'd4};
    tbl[5] = '{1'b1, 16'h0010, 4'b1000, B2, 1, {16'h0, 16'h0, 16'h0, 16'h0010}, {16'h0, 16'h0, 16'h0, 16'hdead}, 16'd1};
    ov_d = '{16'h1, 16'h2, 16'h3, 16'h4, 16'hf00d, 16'hcafe, 16'hbeef, 16'hdead};
    wr_if.ready = 0;
    repeat (2) tick();
    chk("rst_wr_valid", wr_if.valid, 0);
    chk("rst_wr_addr", wr_if.addr, 0);
    chk("rst_wr_data", wr_if.data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_words", words_written, 0);
    chk("rst_capture_ready", capture_ready, 1);
    rst = 0;
    tick();
    do_start(16'h0100);
    wr_if.ready = 1;
    send(4'b1111, B1);
    chk("t1_c0_valid", wr_if.valid, 0);
    chk("t1_c0_busy", busy, 1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("t1_c%0d_valid", k), wr_if.valid, 1);
      chk($sformatf("t1_c%0d_addr", k), wr_if.addr, 16'h00FF + k);
      chk($sformatf("t1_c%0d_data", k), wr_if.data, k);
    end
    tick();
    chk("t1_c5_valid", wr_if.valid, 0);
    chk("t1_c5_busy", busy, 0);
    chk("t1_c5_words", words_written, 4);
    for (int t = 0; t < 6; t++) begin
      if (tbl[t].restart) do_start(tbl[t].base);
      got.delete();
      send(tbl[t].mask, tbl[t].bus);
      drain();
      chk($sformatf("tbl%0d_count", t), got.size(), tbl[t].n);
      for (int j = 0; j < tbl[t].n && j < got.size(); j++)
        chk($sformatf("tbl%0d_word%0d", t, j), got[j], {tbl[t].ea[j], tbl[t].ed[j]});
      chk($sformatf("tbl%0d_words", t), words_written, tbl[t].words);
    end
    do_start(16'h0100);
    pat = 7'b1101001;
    wr_if.ready = 0;
    send(4'b1111, B1);
    tick();
    for (int i = 0; i < 7; i++) begin
      wr_if.ready = pat[i];
      tick();
    end
    drain();
    chk("stall_count", got.size(), 4);
    for (int j = 0; j < 4 && j < got.size(); j++)
      chk($sformatf("stall_word%0d", j), got[j], {16'h0100 + 16'(j), 16'(j + 1)});
    do_start(16'h0400);
    wr_if.ready = 0;
    out_valid = 1;
    out_mask = 4'b1111;
    out_bus = B1;
    tick();
    chk("ovf_ready_after_1st", capture_ready, 1);
    out_bus = B2;
    tick();
    chk("ovf_ready_after_2nd", capture_ready, 0);
    out_bus = 64'h5555_5555_5555_5555;
    tick();
    out_valid = 0;
    chk("ovf_flag", overflow, 1);
    chk("ovf_ready_after_3rd", capture_ready, 0);
    drain();
    chk("ovf_count", got.size(), 8);
    for (int j = 0; j < 8 && j < got.size(); j++)
      chk($sformatf("ovf_word%0d", j), got[j], {16'h0400 + 16'(j), ov_d[j]});
    chk("ovf_words", words_written, 8);
    chk("ovf_sticky", overflow, 1);
    do_start(16'h0100);
    wr_if.ready = 1;
    send(4'b1111, B1);
    tick();
    tick();
    chk("abort_pre_addr", wr_if.addr, 16'h0101);
    do_start(16'h0200);
    chk("abort_valid", wr_if.valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_words", words_written, 0);
    chk("abort_overflow", overflow, 0);
    chk("abort_ready", capture_ready, 1);
    send(4'b0011, B2);
    drain();
    chk("abort_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("abort_word0", got[0], {16'h0200, 16'hf00d});
      chk("abort_word1", got[1], {16'h0201, 16'hcafe});
    end
    start = 1;
    base_addr = 16'h0300;
    out_valid = 1;
    out_mask = 4'b0100;
    out_bus = B2;
    tick();
    start = 0;
    out_valid = 0;
    got.delete();
    drain();
    chk("start_capture_count", got.size(), 1);
    if (got.size() == 1) chk("start_capture_word", got[0], {16'h0300, 16'hbeef});
    do_start(16'h0700);
    wr_if.ready = 0;
    send(4'b1111, B2);
    tick();
    chk("rst_mid_valid_pre", wr_if.valid, 1);
    #2 rst = 1;
    #1;
    chk("arst_wr_valid", wr_if.valid, 0);
    chk("arst_wr_addr", wr_if.addr, 0);
    chk("arst_wr_data", wr_if.data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_words", words_written, 0);
    chk("arst_capture_ready", capture_ready, 1);
    tick();
    rst = 0;
    tick();
    rbase = 16'($urandom_range(0, 65535));
    do_start(rbase);
    exp_q.delete();
    sent = 0;
    for (int c = 0; c < 300; c++) begin
      out_valid = 0;
      if (sent < 40 && capture_ready && $urandom_range(0, 1) == 1) begin
        m = 4'($urandom_range(0, 15));
        b = {$urandom, $urandom};
        out_valid = 1;
        out_mask = m;
        out_bus = b;
        sent++;
        for (int i = 0; i < 4; i++) if (m[i]) exp_q.push_back(b[i*16 +: 16]);
      end
      wr_if.ready = $urandom_range(0, 3) != 0;
      tick();
    end
    out_valid = 0;
    drain();
    chk("rnd_count", got.size(), exp_q.size());
    for (int j = 0; j < exp_q.size() && j < got.size(); j++)
      chk($sformatf("rnd_word%0d", j), got[j], {16'(rbase + 16'(j)), exp_q[j]});
    chk("rnd_words", words_written, 16'(exp_q.size()));
    chk("rnd_overflow", overflow, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
